// File: rtl/vga_pkg.sv
// Shared VGA timing constants and elaboration helpers used by the timing generator.
package vga_pkg;
  localparam int SYNC_ACTIVE_LOW  = 0;
  localparam int SYNC_ACTIVE_HIGH = 1;

  // 640x480 @ 60 Hz default timing set
  localparam int VGA_H_VISIBLE = 640;
  localparam int VGA_H_FRONT   = 16;
  localparam int VGA_H_SYNC    = 96;
  localparam int VGA_H_BACK    = 48;
  localparam int VGA_V_VISIBLE = 480;
  localparam int VGA_V_FRONT   = 10;
  localparam int VGA_V_SYNC    = 2;
  localparam int VGA_V_BACK    = 33;

  function automatic int axis_total(input int visible, input int front,
                                    input int sync, input int back);
    return visible + front + sync + back;
  endfunction

  function automatic int count_width(input int total);
    return (total < 2) ? 1 : $clog2(total);
  endfunction
endpackage

// File: rtl/vga_timing_gen_if.sv
// Pixel clock-enable in, registered timing outputs back to the game and VGA output stage.
interface vga_timing_gen_if
  import vga_pkg::*;
#(
  parameter int X_W     = count_width(axis_total(VGA_H_VISIBLE, VGA_H_FRONT, VGA_H_SYNC, VGA_H_BACK)),
  parameter int Y_W     = count_width(axis_total(VGA_V_VISIBLE, VGA_V_FRONT, VGA_V_SYNC, VGA_V_BACK)),
  parameter int FRAME_W = 8
);
  // No handshake: ce qualifies every clock; outputs are levels except the one-clock start pulses.
  logic               ce;
  logic               hsync;
  logic               vsync;
  logic               blank_n;
  logic               visible;
  logic               pre_visible;
  logic [X_W-1:0]     x;
  logic [Y_W-1:0]     y;
  logic               line_start;
  logic               frame_start;
  logic [FRAME_W-1:0] frame_count;

  modport master (input ce, output hsync, vsync, blank_n, visible, pre_visible,
                  x, y, line_start, frame_start, frame_count);
  modport slave  (output ce, input hsync, vsync, blank_n, visible, pre_visible,
                  x, y, line_start, frame_start, frame_count);
endinterface

// File: rtl/vga_axis_counter.sv
// One timing axis: wrap counter with enable, plus region decode of the position it moves to.
module vga_axis_counter
  import vga_pkg::*;
#(
  parameter int VISIBLE = VGA_H_VISIBLE,
  parameter int FRONT   = VGA_H_FRONT,
  parameter int SYNC    = VGA_H_SYNC,
  parameter int BACK    = VGA_H_BACK,
  parameter int AHEAD   = 0,
  parameter int W       = count_width(axis_total(VISIBLE, FRONT, SYNC, BACK))
) (
  input  logic         clock,
  input  logic         reset_n,
  input  logic         i_en,
  output logic [W-1:0] o_next,
  output logic         o_wrap,
  output logic         o_vis_next,
  output logic         o_sync_next,
  output logic         o_vis_ahead,
  output logic         o_ahead_wrapped
);
  localparam int           TOTAL = axis_total(VISIBLE, FRONT, SYNC, BACK);
  localparam logic [W-1:0] LAST  = W'(TOTAL - 1);

  logic [W-1:0] r_count;
  logic         w_at_last;
  int           w_next_i;
  int           w_ahead_i;

  assign w_at_last = (r_count == LAST);
  assign o_wrap    = i_en && w_at_last;

  always_comb begin
    o_next = r_count;
    if (i_en) o_next = w_at_last ? '0 : r_count + W'(1);
  end

  // AHEAD never exceeds the blanking length, so the lookahead wraps at most once.
  always_comb begin
    w_next_i        = int'(o_next);
    w_ahead_i       = w_next_i + AHEAD;
    o_ahead_wrapped = 1'b0;
    if (w_ahead_i >= TOTAL) begin
      w_ahead_i       = w_ahead_i - TOTAL;
      o_ahead_wrapped = 1'b1;
    end
    o_vis_next  = (w_next_i < VISIBLE);
    o_sync_next = (w_next_i >= VISIBLE + FRONT) && (w_next_i < VISIBLE + FRONT + SYNC);
    o_vis_ahead = (w_ahead_i < VISIBLE);
  end

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) r_count <= LAST;
    else          r_count <= o_next;
  end
endmodule

// File: rtl/vga_timing_gen.sv
// Parametrised VGA timing generator on a single clock with pixel clock-enable; all outputs registered.
module vga_timing_gen
  import vga_pkg::*;
#(
  parameter int H_VISIBLE = VGA_H_VISIBLE,
  parameter int H_FRONT   = VGA_H_FRONT,
  parameter int H_SYNC    = VGA_H_SYNC,
  parameter int H_BACK    = VGA_H_BACK,
  parameter int V_VISIBLE = VGA_V_VISIBLE,
  parameter int V_FRONT   = VGA_V_FRONT,
  parameter int V_SYNC    = VGA_V_SYNC,
  parameter int V_BACK    = VGA_V_BACK,
  parameter int HSYNC_POL = SYNC_ACTIVE_LOW,
  parameter int VSYNC_POL = SYNC_ACTIVE_LOW,
  parameter int LOOKAHEAD = 2,
  parameter int FRAME_W   = 8
) (
  input logic              clock,
  input logic              reset_n,
  vga_timing_gen_if.master bus
);
  localparam int   H_TOTAL = axis_total(H_VISIBLE, H_FRONT, H_SYNC, H_BACK);
  localparam int   V_TOTAL = axis_total(V_VISIBLE, V_FRONT, V_SYNC, V_BACK);
  localparam int   X_W     = count_width(H_TOTAL);
  localparam int   Y_W     = count_width(V_TOTAL);
  localparam logic HS_ACT  = (HSYNC_POL != 0);
  localparam logic VS_ACT  = (VSYNC_POL != 0);

  if (H_VISIBLE < 1 || H_FRONT < 1 || H_SYNC < 1 || H_BACK < 1 ||
      V_VISIBLE < 1 || V_FRONT < 1 || V_SYNC < 1 || V_BACK < 1 || FRAME_W < 1 ||
      LOOKAHEAD < 0 || LOOKAHEAD > H_TOTAL - H_VISIBLE) begin : g_bad_params
    $error("vga_timing_gen: illegal timing parameters");
  end

  logic [X_W-1:0]     w_h_next;
  logic [Y_W-1:0]     w_v_next;
  logic               w_h_wrap, w_h_vis, w_h_sync, w_h_vis_ahead, w_h_ahead_wrap;
  logic               w_v_wrap, w_v_vis, w_v_sync, w_v_vis_next_line, w_v_unused_wrap;

  logic               r_hsync, r_vsync, r_visible, r_pre_visible;
  logic [X_W-1:0]     r_x;
  logic [Y_W-1:0]     r_y;
  logic               r_line_start, r_frame_start, r_first;
  logic [FRAME_W-1:0] r_frame_count;

  vga_axis_counter #(
    .VISIBLE(H_VISIBLE), .FRONT(H_FRONT), .SYNC(H_SYNC), .BACK(H_BACK),
    .AHEAD(LOOKAHEAD), .W(X_W)
  ) u_h (
    .clock(clock), .reset_n(reset_n), .i_en(bus.ce),
    .o_next(w_h_next), .o_wrap(w_h_wrap), .o_vis_next(w_h_vis), .o_sync_next(w_h_sync),
    .o_vis_ahead(w_h_vis_ahead), .o_ahead_wrapped(w_h_ahead_wrap)
  );

  // The vertical lookahead of one line serves pre_visible when the pixel lead crosses a line end.
  vga_axis_counter #(
    .VISIBLE(V_VISIBLE), .FRONT(V_FRONT), .SYNC(V_SYNC), .BACK(V_BACK),
    .AHEAD(1), .W(Y_W)
  ) u_v (
    .clock(clock), .reset_n(reset_n), .i_en(w_h_wrap),
    .o_next(w_v_next), .o_wrap(w_v_wrap), .o_vis_next(w_v_vis), .o_sync_next(w_v_sync),
    .o_vis_ahead(w_v_vis_next_line), .o_ahead_wrapped(w_v_unused_wrap)
  );

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      r_hsync       <= ~HS_ACT;
      r_vsync       <= ~VS_ACT;
      r_visible     <= 1'b0;
      r_pre_visible <= 1'b0;
      r_x           <= '0;
      r_y           <= '0;
      r_line_start  <= 1'b0;
      r_frame_start <= 1'b0;
      r_first       <= 1'b1;
      r_frame_count <= '0;
    end else begin
      r_line_start  <= w_h_wrap;
      r_frame_start <= w_h_wrap && w_v_wrap;
      if (bus.ce) begin
        r_x           <= w_h_next;
        r_y           <= w_v_next;
        r_hsync       <= w_h_sync ? HS_ACT : ~HS_ACT;
        r_vsync       <= w_v_sync ? VS_ACT : ~VS_ACT;
        r_visible     <= w_h_vis && w_v_vis;
        r_pre_visible <= w_h_vis_ahead && (w_h_ahead_wrap ? w_v_vis_next_line : w_v_vis);
        r_first       <= 1'b0;
        // The wrap out of the reset position is the start of frame 0, not a completed frame.
        if (w_v_wrap && !r_first) r_frame_count <= r_frame_count + FRAME_W'(1);
      end
    end
  end

  assign bus.hsync       = r_hsync;
  assign bus.vsync       = r_vsync;
  assign bus.blank_n     = r_visible;
  assign bus.visible     = r_visible;
  assign bus.pre_visible = r_pre_visible;
  assign bus.x           = r_x;
  assign bus.y           = r_y;
  assign bus.line_start  = r_line_start;
  assign bus.frame_start = r_frame_start;
  assign bus.frame_count = r_frame_count;
endmodule
